// File: rtl/dtcm_arbiter.sv
// -----------------------------------------------------------------------------
// dtcm_arbiter
//   Shares a single-port synchronous DTCM between the core load/store path and
//   a DMA/loader requester. The core has fixed priority. A wait counter forces
//   one DMA grant after MAX_WAIT consecutive denials so the DMA always makes
//   forward progress.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   core_minst          4-bit memory op (11xx = none, 0xxx = load, 10xx = store)
//   core_addr/wdata     core byte address, LSB-aligned store data
//   core_stall          core op not accepted this cycle (combinational)
//   dma_req/we/addr/    DMA request (held until granted), direction, word
//   dma_wdata/be        address, write data, byte enables
//   dma_gnt             DMA access issued this cycle (combinational)
//   dma_rvalid/rdata    DMA read return, one cycle after a granted DMA read
//   mem_*               SRAM interface; mem_rdata is valid the cycle after a read
//   misalign_err        one-cycle registered pulse for an accepted misaligned op
// -----------------------------------------------------------------------------
module dtcm_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  core_minst,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_be,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        misalign_err
);

  typedef enum logic {CORE_PRI, DMA_FORCE} arb_state_t;
  typedef enum logic {OWN_CORE, OWN_DMA}   rd_owner_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_t       state;
  rd_owner_t        rd_owner;
  logic [CNT_W-1:0] wait_cnt;
  logic             rd_valid;
  logic [31:0]      rdata_hold;

  logic        core_req;
  logic        core_gnt;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  core_be;
  logic [31:0] core_wd;

  // ---------------------------------------------------------------------------
  // Core op decode
  // ---------------------------------------------------------------------------
  assign core_req = (core_minst[3:2] != 2'b11);
  assign is_store = (core_minst[3:2] == 2'b10);

  // Size lives in minst[1:0] for loads and stores alike (lbu/lhu only set bit 2).
  assign misaligned = ((core_minst[1:0] == 2'b01) & core_addr[0]) |
                      (core_minst[1] & (core_addr[1:0] != 2'b00));

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    core_be = 4'b0000;
    core_wd = 32'h0;
    if (is_store) begin
      case (core_minst[1:0])
        2'b00: begin
          core_be = 4'b0001 << core_addr[1:0];
          core_wd = {4{core_wdata[7:0]}};
        end
        2'b01: begin
          core_be = 4'b0011 << {core_addr[1], 1'b0};
          core_wd = {2{core_wdata[15:0]}};
        end
        default: begin
          core_be = 4'b1111;
          core_wd = core_wdata;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Grants. Both are forced low while reset is asserted. In DMA_FORCE the DMA
  // request is known to be pending (it is held until granted), so the grant
  // simply follows it and the core is stalled.
  // ---------------------------------------------------------------------------
  assign core_gnt   = reset & core_req & (state == CORE_PRI);
  assign dma_gnt    = reset & dma_req & ((state == DMA_FORCE) | ~core_req);
  assign core_stall = core_req & ~core_gnt;

  // ---------------------------------------------------------------------------
  // SRAM request mux; idle outputs are driven to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = core_be;
      mem_addr  = core_addr & ~32'h3;
      mem_wdata = core_wd;
    end else if (dma_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dma_we ? dma_be : 4'b0000;
      mem_addr  = dma_addr & ~32'h3;
      mem_wdata = dma_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration state, wait counter and read-return bookkeeping
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CORE_PRI;
      wait_cnt     <= '0;
      rd_owner     <= OWN_CORE;
      rd_valid     <= 1'b0;
      rdata_hold   <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      if (dma_gnt || !dma_req) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      case (state)
        CORE_PRI:  if (dma_req && !dma_gnt && wait_cnt == WAIT_LAST) state <= DMA_FORCE;
        DMA_FORCE: state <= CORE_PRI;
        default:   state <= CORE_PRI;
      endcase

      rd_valid     <= (core_gnt & ~is_store) | (dma_gnt & ~dma_we);
      rd_owner     <= (dma_gnt & ~dma_we) ? OWN_DMA : OWN_CORE;
      misalign_err <= core_gnt & misaligned;
      if (dma_rvalid) begin
        rdata_hold <= mem_rdata;
      end
    end
  end

  // The SRAM presents read data in the cycle after the access; the DMA sees it
  // in that same cycle and the last value is held afterwards. Core read data
  // goes straight from mem_rdata to the core.
  assign dma_rvalid = rd_valid & (rd_owner == OWN_DMA);
  assign dma_rdata  = dma_rvalid ? mem_rdata : rdata_hold;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dtcm_arbiter
//   Scoreboard bench for dtcm_arbiter. The driver applies one cycle of stimulus
//   shortly after each rising edge, computes the expected outputs for that
//   cycle from a behavioural model and queues them; a monitor pops and compares
//   on every falling edge.
// -----------------------------------------------------------------------------
module tb_dtcm_arbiter;

  localparam int MAX_WAIT = 8;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_minst;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [3:0]  dma_be;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        misalign_err;

  dtcm_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .core_minst(core_minst), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_be(dma_be),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
    logic        rv;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  int denied      = 0;   // consecutive cycles the pending DMA request was refused
  bit force_now   = 0;   // this cycle belongs to the DMA unconditionally
  bit pend_dma_rd = 0;   // a DMA read was issued last cycle
  bit pend_mis    = 0;   // an accepted misaligned core op happened last cycle

  // Outcome of the last driven cycle, used to respect the hold protocols
  bit last_cstall = 0;
  bit last_dreq   = 0;
  bit last_dgnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    denied = 0; force_now = 0; pend_dma_rd = 0; pend_mis = 0;
    last_cstall = 0; last_dreq = 0; last_dgnt = 0;
    sb_q.delete();
  endtask

  // Drive one cycle and queue the expected outputs of that cycle.
  task automatic step(input logic [3:0] minst, input logic [31:0] caddr,
                      input logic [31:0] cwdata, input logic dreq, input logic dwe,
                      input logic [31:0] daddr, input logic [31:0] dwdata,
                      input logic [3:0] dbe);
    exp_t e;
    bit   creq, cgnt, dgnt, store, next_force;
    int   nbytes;
    logic [31:0] rd;
    @(posedge clk);
    #1;
    core_minst = minst; core_addr = caddr; core_wdata = cwdata;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwdata; dma_be = dbe;
    rd = $urandom;
    mem_rdata = rd;

    e.rv    = pend_dma_rd;
    e.rdata = rd;
    e.mis   = pend_mis;

    creq   = (minst[3:2] != 2'b11);
    store  = (minst[3:2] == 2'b10);
    nbytes = (minst[1:0] == 2'b00) ? 1 : (minst[1:0] == 2'b01) ? 2 : 4;
    cgnt   = creq && !force_now;
    dgnt   = dreq && (force_now || !creq);

    e.stall = creq && !cgnt;
    e.gnt   = dgnt;
    e.en    = cgnt || dgnt;
    e.we    = 4'd0;
    e.addr  = 32'd0;
    e.wdata = 32'd0;
    if (cgnt) begin
      e.addr = caddr - (caddr % 4);
      if (store) begin
        if (nbytes == 4) begin
          e.we = 4'd15; e.wdata = cwdata;
        end else if (nbytes == 2) begin
          e.we = 4'(3 << (((caddr % 4) / 2) * 2));
          e.wdata = (cwdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
          e.we = 4'(1 << (caddr % 4));
          e.wdata = (cwdata & 32'hFF) * 32'h0101_0101;
        end
      end
    end else if (dgnt) begin
      e.addr  = daddr - (daddr % 4);
      e.we    = dwe ? dbe : 4'd0;
      e.wdata = dwdata;
    end
    sb_q.push_back(e);

    pend_dma_rd = dgnt && !dwe;
    pend_mis    = cgnt && ((caddr % nbytes) != 0);
    if (dreq && !dgnt) begin
      next_force = !force_now && (denied == MAX_WAIT - 1);
      denied++;
    end else begin
      next_force = 0;
      denied = 0;
    end
    force_now   = next_force;
    last_cstall = e.stall;
    last_dreq   = dreq;
    last_dgnt   = dgnt;
  endtask

  // Monitor: compare every queued cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("core_stall", 32'(core_stall), 32'(e.stall));
      check("dma_gnt", 32'(dma_gnt), 32'(e.gnt));
      check("mem_en", 32'(mem_en), 32'(e.en));
      check("mem_we", 32'(mem_we), 32'(e.we));
      check("mem_addr", mem_addr, e.addr);
      check("mem_wdata", mem_wdata, e.wdata);
      check("misalign_err", 32'(misalign_err), 32'(e.mis));
      check("dma_rvalid", 32'(dma_rvalid), 32'(e.rv));
      if (e.rv) check("dma_rdata", dma_rdata, e.rdata);
    end
  end

  logic [3:0] ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  initial begin
    logic [3:0]  c_op;
    logic [31:0] c_a, c_d, d_a, d_d;
    logic        d_r, d_w;
    logic [3:0]  d_b;

    reset = 1'b0;
    core_minst = OP_NOP; core_addr = 0; core_wdata = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; dma_wdata = 0; dma_be = 0;
    mem_rdata = 32'h0;
    #12;
    check("reset dma_gnt", 32'(dma_gnt), 32'd0);
    check("reset mem_en", 32'(mem_en), 32'd0);
    check("reset dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("reset dma_rdata", dma_rdata, 32'd0);
    check("reset misalign_err", 32'(misalign_err), 32'd0);
    dma_req = 1'b0;
    #10 reset = 1'b1;

    // Core lbu at 0x1003
    step(OP_LBU, 32'h1003, 32'h0, 0, 0, 0, 0, 0);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 0, 0, 0);

    // sh aligned, then misaligned, then idle cycles to see the single pulse
    step(OP_SH, 32'h2002, 32'h1234, 0, 0, 0, 0, 0);
    step(OP_SH, 32'h2001, 32'h1234, 0, 0, 0, 0, 0);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 0, 0, 0);

    // DMA read with the core idle
    step(OP_NOP, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 4'h0);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Continuous core loads starve the DMA until it is forced through
    for (int i = 0; i < 12; i++) begin
      d_r = !(last_dreq && last_dgnt) || i == 0;
      step(OP_LW, 32'h3000, 32'h0, d_r && i < 9, 1'b0, 32'h84, 32'h0, 4'h0);
    end

    // Core sw and DMA write collide; DMA waits for the first idle core cycle
    step(OP_SW, 32'h3010, 32'hDEAD_BEEF, 1, 1, 32'h88, 32'h1122_3344, 4'b0101);
    step(OP_SW, 32'h3014, 32'hCAFE_F00D, 1, 1, 32'h88, 32'h1122_3344, 4'b0101);
    step(OP_NOP, 32'h0, 32'h0, 1, 1, 32'h88, 32'h1122_3344, 4'b0101);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Asynchronous reset in the middle of a forced DMA read
    for (int i = 0; i < MAX_WAIT + 1; i++)
      step(OP_LW, 32'h3100, 32'h0, 1, 0, 32'h90, 32'h0, 4'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid reset dma_gnt", 32'(dma_gnt), 32'd0);
    check("mid reset mem_en", 32'(mem_en), 32'd0);
    check("mid reset core_stall", 32'(core_stall), 32'd1);
    check("mid reset misalign_err", 32'(misalign_err), 32'd0);
    @(posedge clk);
    #1;
    check("mid reset dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("mid reset dma_rdata", dma_rdata, 32'd0);
    model_reset();
    #1 reset = 1'b1;
    // After release both still request: the core must win first
    step(OP_LW, 32'h3100, 32'h0, 1, 0, 32'h90, 32'h0, 4'h0);
    step(OP_NOP, 32'h0, 32'h0, 1, 0, 32'h90, 32'h0, 4'h0);
    step(OP_NOP, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Randomised traffic respecting both hold protocols
    c_op = OP_NOP; c_a = 0; c_d = 0;
    d_r = 0; d_w = 0; d_a = 0; d_d = 0; d_b = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_cstall) begin
        if ($urandom_range(9) < 2) c_op = OP_NOP | 4'($urandom_range(3));
        else c_op = ops[$urandom_range(7)];
        c_a = 32'h1000 + 32'($urandom_range(63));
        c_d = $urandom;
      end
      if (!(last_dreq && !last_dgnt)) begin
        d_r = ($urandom_range(2) == 0);
        d_w = 1'($urandom);
        d_a = $urandom & 32'hFFFF;
        d_d = $urandom;
        d_b = 4'($urandom);
      end
      step(c_op, c_a, c_d, d_r, d_w, d_a, d_d, d_b);
    end
    step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
